// File: rtl/vram_arbiter.sv
// VRAM write-port arbiter: CPU store path > round-robin(echo writer, clear sequencer).
// The clear sequencer is compiled in only when VRAM_ARB_CLEAR_EN is defined.
module vram_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 7,
  parameter int unsigned CELLS  = 4800,
  parameter logic [DATA_W-1:0] BLANK = 7'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  input  logic              echo_req,
  input  logic [ADDR_W-1:0] echo_a,
  input  logic [DATA_W-1:0] echo_d,
  output logic              echo_ack,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_a,
  output logic [DATA_W-1:0] vram_d
);

  localparam logic [ADDR_W-1:0] LastCell = ADDR_W'(CELLS - 1);

  logic              echo_elig;
  logic              clr_req;
  logic [ADDR_W-1:0] clr_a;
  logic              gnt_cpu, gnt_echo, gnt_clr;
  logic              rr_echo_q;  // 1: echo wins the next background tie

  // The ack term blocks a second grant while the requester is still seeing the ack.
  assign echo_elig = echo_req & ~echo_ack;

`ifdef VRAM_ARB_CLEAR_EN
  typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

  clr_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q;

  // A (re)start cycle issues no write; the pass begins at ptr 0 on the next edge.
  assign clr_req = (state_q == StClear) & ~clr_start;
  assign clr_a   = ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      if (clr_start) begin
        state_q  <= StClear;
        ptr_q    <= '0;
        clr_busy <= 1'b1;
      end else if (gnt_clr) begin
        ptr_q <= ptr_q + 1'b1;
        if (ptr_q == LastCell) begin
          state_q  <= StIdle;
          clr_busy <= 1'b0;
          clr_done <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_clr;

  assign clr_req    = 1'b0;
  assign clr_a      = '0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
  assign unused_clr = clr_start ^ (^LastCell);
`endif

  always_comb begin
    gnt_cpu  = cpu_we;
    gnt_echo = 1'b0;
    gnt_clr  = 1'b0;
    if (!cpu_we) begin
      if (echo_elig && clr_req) begin
        gnt_echo = rr_echo_q;
        gnt_clr  = ~rr_echo_q;
      end else begin
        gnt_echo = echo_elig;
        gnt_clr  = clr_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vram_we   <= 1'b0;
      vram_a    <= '0;
      vram_d    <= '0;
      echo_ack  <= 1'b0;
      rr_echo_q <= 1'b1;
    end else begin
      vram_we  <= gnt_cpu | gnt_echo | gnt_clr;
      echo_ack <= gnt_echo;
      if (gnt_cpu) begin
        vram_a <= cpu_a;
        vram_d <= cpu_d;
      end else if (gnt_echo) begin
        vram_a <= echo_a;
        vram_d <= echo_d;
      end else if (gnt_clr) begin
        vram_a <= clr_a;
        vram_d <= BLANK;
      end
      if (gnt_echo || gnt_clr) begin
        rr_echo_q <= gnt_clr;
      end
    end
  end

endmodule
